instruction_cache: RTL and testbench



---
 rtl/instruction_cache.sv | 150 +++++++++++++++
 tb/tb_instruction_cache.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache between the fetch PC and a
// 128-bit instruction memory. Hits return the word combinationally; a miss
// stalls the front end through IDLE -> MEM_READ -> UPDATE.
// Optional: define ICACHE_PERF_COUNT_EN to add hit_count / miss_count outputs.
module instruction_cache #(
  parameter int INDEX_BITS = 3,
  parameter int BLOCK_BITS = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           address,
  output logic [31:0]           readdata,
  output logic                  busywait,
  input  logic                  flush,
  output logic                  mem_read,
  output logic [27:0]           mem_address,
  input  logic [BLOCK_BITS-1:0] mem_readdata,
  input  logic                  mem_busywait
`ifdef ICACHE_PERF_COUNT_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int TAG_W = 28 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tag_arr  [LINES];
  logic [BLOCK_BITS-1:0] data_arr [LINES];

  // Block address of the miss, held for the whole refill so a PC change
  // upstream cannot redirect it.
  logic [27:0]           miss_blk;
  logic [BLOCK_BITS-1:0] fill_buf;
  logic                  flush_pend;

  logic [1:0]            off;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic [INDEX_BITS-1:0] miss_idx;
  logic [TAG_W-1:0]      miss_tag;
  logic                  hit;
  logic                  flush_eff;
  logic [BLOCK_BITS-1:0] line;

  // Byte-offset bits are never used: fetch is always word aligned.
  wire unused_addr_lsb = &{1'b0, address[1:0]};

  assign off       = address[3:2];
  assign idx       = address[3+INDEX_BITS:4];
  assign tag       = address[31:4+INDEX_BITS];
  assign miss_idx  = miss_blk[INDEX_BITS-1:0];
  assign miss_tag  = miss_blk[27:INDEX_BITS];
  assign hit       = valid[idx] && (tag_arr[idx] == tag);
  assign flush_eff = flush || flush_pend;
  assign line      = data_arr[idx];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: flush (direct or deferred) outranks a miss in IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (!flush_eff && !hit) state_nxt = MEM_READ;
      MEM_READ: if (!mem_busywait)      state_nxt = UPDATE;
      UPDATE:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs: mem_read decodes the state register only, so it is glitch-free
  always_comb begin
    mem_read = (state == MEM_READ);
    busywait = 1'b1;
    if (state == IDLE) busywait = flush_eff || !hit;
    readdata = line[{off, 5'b0} +: 32];
    if (reset) begin
      busywait = 1'b0;
      readdata = '0;
    end
  end

  assign mem_address = miss_blk;

  // Valid bits, miss latch and deferred flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid      <= '0;
      miss_blk   <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (state == IDLE && flush_eff)  valid <= '0;
      else if (state == UPDATE)        valid[miss_idx] <= 1'b1;
      if (state == IDLE)               flush_pend <= 1'b0;
      else if (flush)                  flush_pend <= 1'b1;
      if (state == IDLE && state_nxt == MEM_READ) miss_blk <= address[31:4];
    end
  end

  // Refill datapath; tag/data contents are meaningless until valid is set
  always_ff @(posedge clk) begin
    if (state == MEM_READ && !mem_busywait) fill_buf <= mem_readdata;
    if (state == UPDATE) begin
      data_arr[miss_idx] <= fill_buf;
      tag_arr[miss_idx]  <= miss_tag;
    end
  end

`ifdef ICACHE_PERF_COUNT_EN
  logic        prev_stall;
  logic [29:0] last_hit;
  logic        count_hit;
  logic        count_miss;

  assign count_hit  = (state == IDLE) && hit && !flush_eff &&
                      (prev_stall || address[31:2] != last_hit);
  assign count_miss = (state == IDLE) && (state_nxt == MEM_READ);

  // Saturating counters; a held PC under stall counts as one hit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      prev_stall <= 1'b1;
      last_hit   <= '0;
    end else begin
      prev_stall <= busywait;
      if (count_hit) last_hit <= address[31:2];
      if (flush) begin
        hit_count  <= '0;
        miss_count <= '0;
      end else begin
        if (count_hit  && hit_count  != 32'hFFFF_FFFF) hit_count  <= hit_count + 32'd1;
        if (count_miss && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: a cycle-by-cycle vector table covers
// refill, hits, conflict, flush in IDLE and mid-refill; reset during a refill
// is a hand-written sequence. Memory model: 3-cycle latency, each word of a
// block holds its own byte address.
module tb_instruction_cache;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  address;
  logic [31:0]  readdata;
  logic         busywait;
  logic         flush;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int checks = 0;
  int errors = 0;
  int cnt    = 0;

  instruction_cache dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .readdata     (readdata),
    .busywait     (busywait),
    .flush        (flush),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  always #5 clk = ~clk;

  // Memory: busy for LAT-1 cycles of mem_read, data valid on the LAT-th
  always @(posedge clk) begin
    if (mem_read && !mem_busywait) cnt <= 0;
    else if (mem_read)             cnt <= cnt + 1;
    else                           cnt <= 0;
  end
  assign mem_busywait = mem_read && (cnt != LAT - 1);
  assign mem_readdata = {mem_address, 4'hC, mem_address, 4'h8,
                         mem_address, 4'h4, mem_address, 4'h0};

  typedef struct {
    logic [31:0] addr;
    logic        fl;
    logic        busy;
    logic        mrd;
    logic [27:0] maddr;
    logic [31:0] rd;
    logic        chk_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] a, input logic fl, input logic busy,
                     input logic mrd, input logic [27:0] maddr,
                     input logic [31:0] rd, input logic chk_rd);
    vec_t v;
    v.addr = a; v.fl = fl; v.busy = busy; v.mrd = mrd;
    v.maddr = maddr; v.rd = rd; v.chk_rd = chk_rd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full refill from a missing IDLE cycle through the first hit
  task automatic add_refill(input logic [31:0] a);
    add(a, 0, 1, 0, 28'h0, 32'h0, 0);
    for (int k = 0; k < LAT; k++) add(a, 0, 1, 1, a[31:4], 32'h0, 0);
    add(a, 0, 1, 0, 28'h0, 32'h0, 0);
    add(a, 0, 0, 0, 28'h0, {a[31:2], 2'b00}, 1);
  endtask

  initial begin
    // 1: cold miss of 0x0, busywait low 5 cycles after the miss
    add_refill(32'h0000_0000);
    // 2: rest of the block hits back to back
    add(32'h4, 0, 0, 0, 28'h0, 32'h4, 1);
    add(32'h8, 0, 0, 0, 28'h0, 32'h8, 1);
    add(32'hC, 0, 0, 0, 28'h0, 32'hC, 1);
    // 3: conflict on index 0, then 0x0 misses again; PC wanders mid-refill
    add_refill(32'h0000_0080);
    add(32'h0, 0, 1, 0, 28'h0, 32'h0, 0);
    add(32'h0, 0, 1, 1, 28'h0, 32'h0, 0);
    add(32'h10, 0, 1, 1, 28'h0, 32'h0, 0);
    add(32'h0, 0, 1, 1, 28'h0, 32'h0, 0);
    add(32'h0, 0, 1, 0, 28'h0, 32'h0, 0);
    add(32'h0, 0, 0, 0, 28'h0, 32'h0, 1);
    // 4: flush in IDLE stalls one cycle, then the same PC misses
    add(32'h0, 1, 1, 0, 28'h0, 32'h0, 0);
    add_refill(32'h0000_0000);
    // 5: flush mid-refill of 0x100 is deferred to the IDLE return
    add(32'h100, 0, 1, 0, 28'h0, 32'h0, 0);
    add(32'h100, 1, 1, 1, 28'h10, 32'h0, 0);
    add(32'h100, 0, 1, 1, 28'h10, 32'h0, 0);
    add(32'h100, 0, 1, 1, 28'h10, 32'h0, 0);
    add(32'h100, 0, 1, 0, 28'h0, 32'h0, 0);
    add(32'h100, 0, 1, 0, 28'h0, 32'h0, 0);
    add_refill(32'h0000_0100);

    reset = 1'b1; address = 32'h0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busywait", {31'b0, busywait}, 32'h0);
    chk("reset_mem_read", {31'b0, mem_read}, 32'h0);
    chk("reset_mem_address", {4'b0, mem_address}, 32'h0);
    chk("reset_readdata", readdata, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      address = vecs[i].addr;
      flush   = vecs[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d_busywait", i), {31'b0, busywait}, {31'b0, vecs[i].busy});
      chk($sformatf("v%0d_mem_read", i), {31'b0, mem_read}, {31'b0, vecs[i].mrd});
      if (vecs[i].mrd) chk($sformatf("v%0d_mem_address", i), {4'b0, mem_address}, {4'b0, vecs[i].maddr});
      if (vecs[i].chk_rd) chk($sformatf("v%0d_readdata", i), readdata, vecs[i].rd);
      @(posedge clk);
      #1;
    end

    // 6: async reset during MEM_READ, then 0x0 (valid before) must miss
    flush = 1'b0;
    address = 32'h20;
    @(posedge clk); #1;
    chk("r6_in_mem_read", {31'b0, mem_read}, 32'h1);
    reset = 1'b1;
    #1;
    chk("r6_async_mem_read", {31'b0, mem_read}, 32'h0);
    chk("r6_async_busywait", {31'b0, busywait}, 32'h0);
    chk("r6_async_mem_address", {4'b0, mem_address}, 32'h0);
    chk("r6_async_readdata", readdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    address = 32'h0;
    @(negedge clk);
    chk("r6_post_busywait", {31'b0, busywait}, 32'h1);
    chk("r6_post_idle", {31'b0, mem_read}, 32'h0);
    @(negedge clk);
    chk("r6_post_mem_read", {31'b0, mem_read}, 32'h1);
    chk("r6_post_mem_address", {4'b0, mem_address}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
